// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, oversampled 3-point majority vote, one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (PARITY_ODD selects odd parity).
module uart_rx_core #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err_o,
`endif
    output logic                 busy_o,
    output logic [2:0]           dbg_state
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCNT_W  = $clog2(OVERSAMPLE);
    localparam int BIDX_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT
    } state_t;

    // Handshake: a byte transfers on every cycle where valid_o && ready_i are both high at the clk edge;
    // valid_o never drops without that transfer, and ready_i has no effect while valid_o is low.
    state_t              state, state_d;
    logic                sync1, sync2, rx_s;
    logic [DIV_W-1:0]    div_cnt;
    logic [SCNT_W-1:0]   scnt;
    logic [BIDX_W-1:0]   bidx;
    logic                samp_a, samp_b, bit_val, vote;
    logic [DATA_BITS-1:0] shreg;
    logic                tick, mid, wrap, last_bit;
    logic                start_frame, shift_en, par_en, complete;
    logic                par_bad, load;

    assign rx_s      = sync2;
    assign busy_o    = (state != S_IDLE);
    assign dbg_state = state;

    assign tick     = busy_o && (div_cnt == DIV_W'(DIV - 1));
    assign mid      = tick && (scnt == SCNT_W'(OVERSAMPLE / 2 + 1));
    assign wrap     = tick && (scnt == SCNT_W'(OVERSAMPLE - 1));
    assign last_bit = (bidx == BIDX_W'(DATA_BITS - 1));
    // Third sample is taken live on the vote tick itself.
    assign vote     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign load     = complete && vote && !par_bad && (!valid_o || ready_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        par_en      = 1'b0;
        complete    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d     = S_START;
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (mid && vote) begin
                    state_d = S_IDLE;
                end else if (wrap) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                par_en = mid;
                if (wrap) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Finish at mid-stop so a back-to-back start edge is not missed.
                if (mid) begin
                    complete = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            div_cnt     <= '0;
            scnt        <= '0;
            bidx        <= '0;
            samp_a      <= 1'b1;
            samp_b      <= 1'b1;
            bit_val     <= 1'b1;
            shreg       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;

            if (state == S_IDLE || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (state == S_IDLE || wrap) begin
                scnt <= '0;
            end else if (tick) begin
                scnt <= scnt + 1'b1;
            end

            if (start_frame) begin
                bidx <= '0;
            end else if (shift_en) begin
                bidx <= bidx + 1'b1;
            end

            if (tick && scnt == SCNT_W'(OVERSAMPLE / 2 - 1)) samp_a <= rx_s;
            if (tick && scnt == SCNT_W'(OVERSAMPLE / 2))     samp_b <= rx_s;
            if (mid) bit_val <= vote;
            if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};

            if (load) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            frame_err_o <= complete && !vote;
            overrun_o   <= complete && vote && !par_bad && valid_o && !ready_i;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    assign par_bad = (^shreg) ^ par_bit ^ PARITY_ODD;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_bit      <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            if (par_en) par_bit <= vote;
            parity_err_o <= complete && par_bad;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at DIV=1 (16 cycles per bit); parity cases build only with UART_RX_PARITY_EN.
module tb_uart_rx_core;
  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
  logic [2:0] dbg_state;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  uart_rx_core #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o     (busy_o),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int pop_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted byte must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) begin
        pop_cnt++;
        check("pop_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
      end
      if (frame_err_o) ferr_cnt++;
      if (overrun_o) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) perr_cnt++;
`endif
      if (valid_o && !prev_valid) rise_cyc = cyc;
    end
    prev_valid = valid_o;
  end

  // driver tasks
  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 rx_i = bits[i];
      if (i == 0) fall_cyc = cyc;
      repeat (15) @(posedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bits({6'b0, stop_bit, b, 1'b0}, 10);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 ready_i = r;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy_o), 32'd0);
  endtask

  int p0, f0, o0, q0;
  logic [7:0] vec [4] = '{8'h00, 8'hFF, 8'h80, 8'h01};

  initial begin
    rx_i    = 1'b1;
    ready_i = 1'b0;
    rst_n   = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_ferr", 32'(frame_err_o), 32'h0);
    check("rst_ovr", 32'(overrun_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // single byte, consumer always ready
    set_ready(1'b1);
    p0 = pop_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    wait_idle("a5_idle");
    repeat (4) @(negedge clk);
    check("a5_pops", 32'(pop_cnt - p0), 32'd1);
    check("a5_latency", 32'(rise_cyc - fall_cyc), 32'd157);
    check("a5_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("a5_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("a5_valid_low", 32'(valid_o), 32'd0);

    // boundary bit patterns
    for (int i = 0; i < 4; i++) begin
      p0 = pop_cnt;
      exp_q.push_back(vec[i]);
      send_byte(vec[i], 1'b1);
      wait_idle("vec_idle");
      repeat (4) @(negedge clk);
      check("vec_pops", 32'(pop_cnt - p0), 32'd1);
    end

    // back-to-back with stalled consumer -> overrun
    set_ready(1'b0);
    p0 = pop_cnt; o0 = ovr_cnt;
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_idle("b2b_idle");
    repeat (4) @(negedge clk);
    check("b2b_valid", 32'(valid_o), 32'd1);
    check("b2b_data", 32'(data_o), 32'h3C);
    check("b2b_ovr", 32'(ovr_cnt - o0), 32'd1);
    exp_q.push_back(8'h3C);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check("b2b_pops", 32'(pop_cnt - p0), 32'd1);
    check("b2b_valid_low", 32'(valid_o), 32'd0);

    // 5-cycle glitch is rejected in START
    p0 = pop_cnt; f0 = ferr_cnt;
    @(posedge clk);
    #1 rx_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx_i = 1'b1;
    wait_idle("glitch_idle");
    repeat (20) @(negedge clk);
    check("glitch_pops", 32'(pop_cnt - p0), 32'd0);
    check("glitch_valid", 32'(valid_o), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

    // frame error followed by break, then good frame
    p0 = pop_cnt; f0 = ferr_cnt;
    send_byte(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_valid", 32'(valid_o), 32'd0);
    check("break_busy", 32'(busy_o), 32'd1);
    #1 rx_i = 1'b1;
    wait_idle("break_idle");
    repeat (10) @(posedge clk);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    wait_idle("0f_idle");
    repeat (4) @(negedge clk);
    check("0f_pops", 32'(pop_cnt - p0), 32'd1);
    check("0f_ferr", 32'(ferr_cnt - f0), 32'd1);

    // reset during bit 4 while a byte is held
    set_ready(1'b0);
    send_byte(8'h5A, 1'b1);
    wait_idle("hold_idle");
    check("hold_valid", 32'(valid_o), 32'd1);
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_bits(16'h01E, 5);
    @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_data", 32'(data_o), 32'h0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_valid", 32'(valid_o), 32'd0);
    check("post_rst_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("post_rst_ovr", 32'(ovr_cnt - o0), 32'd0);
    set_ready(1'b1);
    p0 = pop_cnt;
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_idle("81_idle");
    repeat (4) @(negedge clk);
    check("81_pops", 32'(pop_cnt - p0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 has three ones, so the correct parity bit is 1
    p0 = pop_cnt; q0 = perr_cnt;
    send_bits({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    wait_idle("par_bad_idle");
    repeat (4) @(negedge clk);
    check("par_bad_pulse", 32'(perr_cnt - q0), 32'd1);
    check("par_bad_pops", 32'(pop_cnt - p0), 32'd0);
    exp_q.push_back(8'h07);
    send_bits({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    wait_idle("par_ok_idle");
    repeat (4) @(negedge clk);
    check("par_ok_pulse", 32'(perr_cnt - q0), 32'd1);
    check("par_ok_pops", 32'(pop_cnt - p0), 32'd1);
`endif

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
